// File: rtl/mpi_lane_engine.sv
// mpi_lane_engine: per-lane command engine behind the MPI controller.
// Takes an opcode word followed by a byte-length word, then either fills the
// local buffer from the rx stream (RECV) or streams the buffer out on tx (SEND).
module mpi_lane_engine #(
    parameter int unsigned W = 128,
    parameter int unsigned X = 3,
    parameter int unsigned D = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] cmd_data,
    input  logic         cmd_valid,
    output logic         status_valid,
    input  logic [W-1:0] rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [W-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         err
);

    localparam int unsigned BPB       = (W * X) / 8;
    localparam int unsigned CAP       = 1 << D;
    localparam int unsigned MAX_BYTES = CAP * BPB;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OPC_SEEN = 2'd1,
        S_RECV     = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           op_send_q, op_send_d;
    logic           op_bad_q, op_bad_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [D-1:0]   beat_cnt_q, beat_cnt_d;
    logic           status_valid_q, status_valid_d;
    logic           rx_ready_q, rx_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic [W-1:0]   tx_data_q, tx_data_d;
    logic           err_q, err_d;

    logic [W-1:0]   mem_q [CAP];

    logic           rx_fire_c;
    logic           tx_fire_c;
    logic           last_beat_c;
    logic           buf_we_c;
    logic [W-1:0]   rem_step_c;
    logic [D-1:0]   beat_nxt_c;

    // Handshake qualifiers and byte accounting shared by both stream states
    always_comb begin
        rx_fire_c   = (state_q == S_RECV) && rx_valid && rx_ready_q;
        tx_fire_c   = (state_q == S_SEND) && tx_valid_q && tx_ready;
        // Final beat: remaining bytes fit in one beat, or buffer capacity reached
        last_beat_c = (rem_q <= W'(BPB)) || (beat_cnt_q == {D{1'b1}});
        rem_step_c  = (rem_q > W'(BPB)) ? (rem_q - W'(BPB)) : '0;
        beat_nxt_c  = beat_cnt_q + D'(1);
        buf_we_c    = rx_fire_c && reset;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        op_send_d      = op_send_q;
        op_bad_d       = op_bad_q;
        rem_d          = rem_q;
        beat_cnt_d     = beat_cnt_q;
        status_valid_d = status_valid_q;
        rx_ready_d     = rx_ready_q;
        tx_valid_d     = tx_valid_q;
        tx_data_d      = tx_data_q;
        err_d          = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d        = S_OPC_SEEN;
                    op_send_d      = (cmd_data == W'(1));
                    op_bad_d       = (cmd_data > W'(1));
                    status_valid_d = 1'b0;
                end
            end
            S_OPC_SEEN: begin
                if (cmd_valid) begin
                    rem_d      = cmd_data;
                    beat_cnt_d = '0;
                    if (op_bad_q) begin
                        // Length word consumed and dropped
                        err_d          = 1'b1;
                        state_d        = S_IDLE;
                        status_valid_d = 1'b1;
                    end else if (cmd_data == '0) begin
                        state_d        = S_IDLE;
                        status_valid_d = 1'b1;
                    end else begin
                        // Oversized message is flagged and clamped to CAP beats
                        if (cmd_data > W'(MAX_BYTES)) begin
                            err_d = 1'b1;
                        end
                        if (op_send_q) begin
                            state_d    = S_SEND;
                            tx_valid_d = 1'b1;
                            tx_data_d  = mem_q[0];
                        end else begin
                            state_d    = S_RECV;
                            rx_ready_d = 1'b1;
                        end
                    end
                end
            end
            S_RECV: begin
                if (rx_fire_c) begin
                    rem_d      = rem_step_c;
                    beat_cnt_d = beat_nxt_c;
                    if (last_beat_c) begin
                        state_d        = S_IDLE;
                        rx_ready_d     = 1'b0;
                        status_valid_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (tx_fire_c) begin
                    rem_d      = rem_step_c;
                    beat_cnt_d = beat_nxt_c;
                    if (last_beat_c) begin
                        state_d        = S_IDLE;
                        tx_valid_d     = 1'b0;
                        status_valid_d = 1'b1;
                    end else begin
                        tx_data_d = mem_q[beat_nxt_c];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            op_send_q      <= 1'b0;
            op_bad_q       <= 1'b0;
            rem_q          <= '0;
            beat_cnt_q     <= '0;
            status_valid_q <= 1'b1;
            rx_ready_q     <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_send_q      <= op_send_d;
            op_bad_q       <= op_bad_d;
            rem_q          <= rem_d;
            beat_cnt_q     <= beat_cnt_d;
            status_valid_q <= status_valid_d;
            rx_ready_q     <= rx_ready_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            err_q          <= err_d;
        end
    end

    // Message buffer; contents intentionally survive reset
    always_ff @(posedge clock) begin
        if (buf_we_c) begin
            mem_q[beat_cnt_q] <= rx_data;
        end
    end

    assign status_valid = status_valid_q;
    assign rx_ready     = rx_ready_q;
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mpi_lane_engine.sv
// Directed self-checking bench for mpi_lane_engine (W=128, X=3, D=5).
module tb_mpi_lane_engine;

    localparam int unsigned W = 128;

    logic         clock;
    logic         reset;
    logic [W-1:0] cmd_data;
    logic         cmd_valid;
    logic         status_valid;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    mpi_lane_engine #(.W(128), .X(3), .D(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .status_valid (status_valid),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present opcode then length on consecutive edges
    task automatic issue(input logic [W-1:0] op, input logic [W-1:0] len);
        cmd_data  = op;
        cmd_valid = 1'b1;
        tick();
        chk("status_after_opc", W'(status_valid), W'(0));
        cmd_data = len;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    // Offer rx beats (data = base + index) until completion; return accepted count
    task automatic run_recv(input int base, output int cnt);
        int  cyc;
        logic hs;
        cnt = 0;
        cyc = 0;
        rx_valid = 1'b1;
        while (!status_valid && cyc < 200) begin
            rx_data = W'(base + cnt);
            hs = rx_ready;
            tick();
            if (hs) cnt++;
            cyc++;
        end
        rx_valid = 1'b0;
        chk("recv_timeout", W'(cyc < 200), W'(1));
    endtask

    int   cnt;
    int   idx;
    int   cyc;
    logic tr;
    logic hs;
    logic stall;
    logic [W-1:0] held;
    logic [W-1:0] exp_d;

    initial begin
        reset     = 1'b0;
        cmd_data  = '0;
        cmd_valid = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_status", W'(status_valid), W'(1));
        chk("rst_tx_valid", W'(tx_valid), W'(0));
        chk("rst_rx_ready", W'(rx_ready), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_tx_data", tx_data, W'(0));
        reset = 1'b1;
        tick();

        // Full RECV, 1536 bytes = 32 beats
        issue(W'(0), W'(1536));
        chk("recv_status_low", W'(status_valid), W'(0));
        chk("recv_rx_ready_up", W'(rx_ready), W'(1));
        run_recv(0, cnt);
        chk("recv_beats", W'(cnt), W'(32));
        chk("recv_rx_ready_down", W'(rx_ready), W'(0));
        chk("recv_status_done", W'(status_valid), W'(1));
        chk("recv_err", W'(err), W'(0));

        // SEND with alternating backpressure
        issue(W'(1), W'(1536));
        chk("send_tx_valid_up", W'(tx_valid), W'(1));
        idx = 0;
        cyc = 0;
        tr  = 1'b1;
        while (!(status_valid && !tx_valid) && cyc < 200) begin
            tx_ready = tr;
            hs    = tx_valid && tr;
            stall = tx_valid && !tr;
            held  = tx_data;
            if (hs) begin
                chk("send_data", tx_data, W'(idx));
                idx++;
            end
            tick();
            cyc++;
            if (stall) begin
                chk("send_hold_valid", W'(tx_valid), W'(1));
                chk("send_hold_data", tx_data, held);
            end
            tr = !tr;
        end
        tx_ready = 1'b0;
        chk("send_timeout", W'(cyc < 200), W'(1));
        chk("send_beats", W'(idx), W'(32));
        chk("send_status_done", W'(status_valid), W'(1));
        chk("send_tx_valid_down", W'(tx_valid), W'(0));
        chk("send_err", W'(err), W'(0));

        // Partial length: 100 bytes = 48 + 48 + 4 -> 3 beats
        issue(W'(0), W'(100));
        run_recv(100, cnt);
        chk("part_beats", W'(cnt), W'(3));
        chk("part_status", W'(status_valid), W'(1));
        tick();
        chk("part_rx_ready", W'(rx_ready), W'(0));

        // Zero length: one cycle low, no streams
        issue(W'(0), W'(0));
        chk("zero_status", W'(status_valid), W'(1));
        chk("zero_rx_ready", W'(rx_ready), W'(0));
        chk("zero_tx_valid", W'(tx_valid), W'(0));
        chk("zero_err", W'(err), W'(0));

        // Illegal opcode
        issue(W'(7), W'(64));
        chk("ill_err", W'(err), W'(1));
        chk("ill_status", W'(status_valid), W'(1));
        chk("ill_rx_ready", W'(rx_ready), W'(0));
        chk("ill_tx_valid", W'(tx_valid), W'(0));
        tick();
        chk("ill_idle_rx", W'(rx_ready), W'(0));
        chk("ill_idle_tx", W'(tx_valid), W'(0));

        // Clear err, then overflow SEND of 3000 bytes -> clamped to 32 beats
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("clr_err", W'(err), W'(0));
        issue(W'(1), W'(3000));
        chk("ovf_err", W'(err), W'(1));
        idx = 0;
        cyc = 0;
        tx_ready = 1'b1;
        while (!(status_valid && !tx_valid) && cyc < 200) begin
            if (tx_valid) begin
                exp_d = (idx < 3) ? W'(100 + idx) : W'(idx);
                chk("ovf_data", tx_data, exp_d);
                idx++;
            end
            tick();
            cyc++;
        end
        tx_ready = 1'b0;
        chk("ovf_timeout", W'(cyc < 200), W'(1));
        chk("ovf_beats", W'(idx), W'(32));
        chk("ovf_status", W'(status_valid), W'(1));

        // Repeat overflow, reset after 10 beats
        issue(W'(1), W'(3000));
        tx_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 50) begin
            if (tx_valid) idx++;
            tick();
            cyc++;
        end
        chk("mid_beats", W'(idx), W'(10));
        chk("mid_busy", W'(tx_valid), W'(1));
        chk("mid_err_set", W'(err), W'(1));
        reset = 1'b0;
        tick();
        chk("mid_tx_valid", W'(tx_valid), W'(0));
        chk("mid_status", W'(status_valid), W'(1));
        chk("mid_err_clr", W'(err), W'(0));
        chk("mid_rx_ready", W'(rx_ready), W'(0));
        reset    = 1'b1;
        tx_ready = 1'b0;
        tick();
        chk("post_idle_tx", W'(tx_valid), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
